axi4lite_pwm_led_ctrl: RTL

AXI4-Lite slave giving the Sapphire SoC N_CH independent PWM-dimmed LED/GPIO outputs plus a period-wrap interrupt. It sits in the top-level user AXI4-Lite slot next to the soc instance. Its interrupt drives userInterruptA. It replaces fixed LED wiring with a register-programmable, width- and channel-parametrised peripheral.

---
 rtl/axi4lite_pwm_led_ctrl.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_pwm_led_ctrl.sv
// AXI4-Lite slave driving N_CH PWM outputs with a period-wrap interrupt.
// Optional PWM_DUTY_SHADOW_EN: duty writes apply at the next period wrap (or at once while disabled).
module axi4lite_pwm_led_ctrl #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int PRE_W  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              io_systemClk,
  input  logic              io_asyncResetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [N_CH-1:0]   pwm_out,
  output logic              irq
);

  // wr_state | meaning
  // S_IDLE   | waiting for both AW and W beats
  // S_AW     | address held, waiting for data
  // S_W      | data held, waiting for address
  // S_WR     | both held, register update this cycle
  // S_RESP   | bvalid high until bready
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_WR, S_RESP} wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         REG_END     = 16 + 4 * N_CH;

  wr_state_t         wr_state, wr_next;
  logic [1:0]        ctrl;
  logic [PRE_W-1:0]  prescale;
  logic              status_wrap;
  logic [CNT_W-1:0]  duty_reg [N_CH];
  logic [CNT_W-1:0]  duty_eff [N_CH];
  logic [ADDR_W-1:0] aw_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [PRE_W-1:0]  pre_cnt;
  logic [CNT_W-1:0]  pwm_cnt;
  logic              en, tick, wrap, aw_hs, w_hs;
  logic [31:0]       wr_addr, rd_addr, wr_mask, wr_merged;
  logic              wr_ok, rd_ok, wr_fire;
  logic              unused_bits;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(REG_END));
  endfunction

  function automatic logic [31:0] reg_value(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      32'h00:  v = {30'd0, ctrl};
      32'h04:  v = 32'(prescale);
      32'h08:  v = {31'd0, status_wrap};
      32'h0C:  v = {16'd0, 8'(CNT_W), 8'(N_CH)};
      default: begin
        for (int i = 0; i < N_CH; i++)
          if (a == 32'(16 + 4 * i)) v = 32'(duty_reg[i]);
      end
    endcase
    return v;
  endfunction

  assign en    = ctrl[0];
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  always_comb begin
    wr_addr   = 32'(aw_addr);
    rd_addr   = 32'(s_axi_araddr);
    wr_ok     = addr_ok(wr_addr);
    rd_ok     = addr_ok(rd_addr);
    wr_mask   = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    wr_merged = (reg_value(wr_addr) & ~wr_mask) | (w_data & wr_mask);
    wr_fire   = (wr_state == S_WR) && wr_ok;
  end

  assign unused_bits = ^wr_merged;

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) wr_state <= S_IDLE;
    else                 wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      S_IDLE: begin
        if (aw_hs && w_hs) wr_next = S_WR;
        else if (aw_hs)    wr_next = S_AW;
        else if (w_hs)     wr_next = S_W;
      end
      S_AW:    if (w_hs) wr_next = S_WR;
      S_W:     if (aw_hs) wr_next = S_WR;
      S_WR:    wr_next = S_RESP;
      S_RESP:  if (s_axi_bready) wr_next = S_IDLE;
      default: wr_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = (wr_state == S_IDLE) || (wr_state == S_W);
    s_axi_wready  = (wr_state == S_IDLE) || (wr_state == S_AW);
    s_axi_bvalid  = (wr_state == S_RESP);
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      aw_addr     <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      if (aw_hs) aw_addr <= s_axi_awaddr;
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (wr_state == S_WR) s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      ctrl     <= '0;
      prescale <= '0;
      for (int i = 0; i < N_CH; i++) duty_reg[i] <= '0;
    end else if (wr_fire) begin
      if (wr_addr == 32'h00) ctrl <= wr_merged[1:0];
      if (wr_addr == 32'h04) prescale <= wr_merged[PRE_W-1:0];
      for (int i = 0; i < N_CH; i++)
        if (wr_addr == 32'(16 + 4 * i)) duty_reg[i] <= wr_merged[CNT_W-1:0];
    end
  end

  // A wrap in the same cycle as a W1C wins, so no event is lost.
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      status_wrap <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (wrap)
        status_wrap <= 1'b1;
      else if (wr_fire && (wr_addr == 32'h08) && w_strb[0] && w_data[0])
        status_wrap <= 1'b0;
      irq <= status_wrap && ctrl[1];
    end
  end

  assign s_axi_arready = !s_axi_rvalid;

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && s_axi_arready) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_ok ? reg_value(rd_addr) : 32'd0;
      s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  assign tick = en && (pre_cnt == prescale);
  assign wrap = tick && (&pwm_cnt);

  // pre_cnt above a freshly lowered PRESCALE restarts at 0 without a tick.
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!en) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= (pre_cnt >= prescale) ? '0 : pre_cnt + PRE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + CNT_W'(1);
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      for (int i = 0; i < N_CH; i++) duty_eff[i] <= '0;
    end else if (wrap || !en) begin
      for (int i = 0; i < N_CH; i++) duty_eff[i] <= duty_reg[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_CH; i++) duty_eff[i] = duty_reg[i];
  end
`endif

  always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) pwm_out[i] <= en && (pwm_cnt < duty_eff[i]);
    end
  end

endmodule
